// File: rtl/smoldvi_tmds_encoder_if.sv
// Symbol-stream bundle for one TMDS colour channel: pixel/control inputs in,
// one 10-bit TMDS symbol out per pixel clock.
interface smoldvi_tmds_encoder_if;
    logic       den;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] q;

    modport master (
        output den,
        output d,
        output c,
        input  q
    );

    modport slave (
        input  den,
        input  d,
        input  c,
        output q
    );
endinterface

// File: rtl/smoldvi_tmds_encoder.sv
// Two-stage DVI TMDS encoder for one colour channel: stage 1 builds the
// transition-minimised q_m word, stage 2 applies DC balancing or control symbols.
module smoldvi_tmds_encoder (
    input  logic                         clk_pix,
    input  logic                         rst_pix,
    smoldvi_tmds_encoder_if.slave        bus
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // q_m[8] set means the XOR chain was used, clear means XNOR.
    function automatic logic [8:0] qm_encode(input logic [7:0] v);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] r;
        n1       = popcount8(v);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (v[0] == 1'b0));
        r        = 9'd0;
        r[0]     = v[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = (r[i-1] ^ v[i]) ^ use_xnor;
        end
        r[8] = ~use_xnor;
        return r;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] code);
        logic [9:0] s;
        case (code)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            2'b11:   s = 10'h2AB;
            default: s = 10'h354;
        endcase
        return s;
    endfunction

    logic       den_s1_d;
    logic       den_s1_q;
    logic [1:0] c_s1_d;
    logic [1:0] c_s1_q;
    logic [8:0] qm_s1_d;
    logic [8:0] qm_s1_q;

    logic [5:0] cnt_d;
    logic [5:0] cnt_q;
    logic [9:0] sym_d;
    logic [9:0] sym_q;

    logic [3:0] n1q_s;
    logic [5:0] diff_s;
    logic       qm8_s;
    logic       cnt_zero_s;
    logic       cnt_pos_s;
    logic       cnt_neg_s;
    logic       balanced_s;
    logic       ones_more_s;
    logic       zeros_more_s;

    // Stage 1 next state: capture mode and control code, build q_m from pixel data.
    always_comb begin
        den_s1_d = bus.den;
        c_s1_d   = bus.c;
        qm_s1_d  = qm_encode(bus.d);
    end

    // Stage 1 registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            den_s1_q <= 1'b0;
            c_s1_q   <= 2'b00;
            qm_s1_q  <= 9'd0;
        end else begin
            den_s1_q <= den_s1_d;
            c_s1_q   <= c_s1_d;
            qm_s1_q  <= qm_s1_d;
        end
    end

    // Stage 2 decision terms; n1q - n0q equals 2*n1q - 8 over the eight data bits.
    always_comb begin
        qm8_s        = qm_s1_q[8];
        n1q_s        = popcount8(qm_s1_q[7:0]);
        diff_s       = {1'b0, n1q_s, 1'b0} - 6'd8;
        cnt_zero_s   = (cnt_q == 6'd0);
        cnt_neg_s    = cnt_q[5];
        cnt_pos_s    = ~cnt_q[5] & ~cnt_zero_s;
        balanced_s   = (n1q_s == 4'd4);
        ones_more_s  = (n1q_s > 4'd4);
        zeros_more_s = (n1q_s < 4'd4);
    end

    // Stage 2 next state: symbol selection and running-disparity update (mod-64 two's complement).
    always_comb begin
        sym_d = sym_q;
        cnt_d = cnt_q;
        if (!den_s1_q) begin
            sym_d = ctrl_symbol(c_s1_q);
            cnt_d = 6'd0;
        end else if (cnt_zero_s || balanced_s) begin
            sym_d = {~qm8_s, qm8_s, (qm8_s ? qm_s1_q[7:0] : ~qm_s1_q[7:0])};
            if (qm8_s) begin
                cnt_d = cnt_q + diff_s;
            end else begin
                cnt_d = cnt_q - diff_s;
            end
        end else if ((cnt_pos_s && ones_more_s) || (cnt_neg_s && zeros_more_s)) begin
            sym_d = {1'b1, qm8_s, ~qm_s1_q[7:0]};
            cnt_d = cnt_q + {4'd0, qm8_s, 1'b0} - diff_s;
        end else begin
            sym_d = {1'b0, qm8_s, qm_s1_q[7:0]};
            cnt_d = cnt_q - {4'd0, ~qm8_s, 1'b0} + diff_s;
        end
    end

    // Stage 2 registers; reset leaves the link idling on control code 00.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cnt_q <= 6'd0;
            sym_q <= 10'h354;
        end else begin
            cnt_q <= cnt_d;
            sym_q <= sym_d;
        end
    end

    assign bus.q = sym_q;

endmodule

// File: tb/tb_smoldvi_tmds_encoder.sv
// Self-checking bench: behavioural TMDS model plus decoder back-check, directed
// literal expectations, then randomised pixel/control/reset stimulus.
module tb_smoldvi_tmds_encoder;

    logic clk_pix;
    logic rst_pix;
    smoldvi_tmds_encoder_if bus();

    smoldvi_tmds_encoder dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .bus     (bus)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [9:0] lit_q[int];
    int         lit_cnt[int];

    function automatic logic [9:0] model_sym(input logic den_v, input logic [7:0] dv,
                                             input logic [1:0] cv, inout int cnt);
        int n1, n1q;
        logic use_xnor, inv, qm8;
        logic [7:0] qm;
        logic [9:0] s;
        if (!den_v) begin
            cnt = 0;
            case (cv)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        n1 = $countones(dv);
        use_xnor = (n1 > 4) || (n1 == 4 && dv[0] == 1'b0);
        qm[0] = dv[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ dv[i]) : (qm[i-1] ^ dv[i]);
        qm8 = !use_xnor;
        n1q = $countones(qm);
        if (cnt == 0 || n1q == 4) inv = !qm8;
        else inv = (cnt > 0 && n1q > 4) || (cnt < 0 && n1q < 4);
        s = {inv, qm8, (inv ? ~qm : qm)};
        cnt = cnt + 2 * $countones(s) - 10;
        return s;
    endfunction

    // Returns {is_control, recovered value}.
    function automatic logic [8:0] decode_sym(input logic [9:0] s);
        logic [7:0] v, r;
        case (s)
            10'h354: return 9'h100;
            10'h0AB: return 9'h101;
            10'h154: return 9'h102;
            10'h2AB: return 9'h103;
            default: ;
        endcase
        v = s[9] ? ~s[7:0] : s[7:0];
        r[0] = v[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return {1'b0, r};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Compare process: advance the model on every edge, then check the DUT 1 ns later.
    initial begin : compare
        logic started, s1_den, e_den;
        logic [7:0] s1_d, e_d;
        logic [1:0] s1_c, e_c;
        logic [9:0] e_q;
        int m_cnt, d_cnt;
        started = 1'b0; s1_den = 1'b0; s1_d = 8'd0; s1_c = 2'b00; m_cnt = 0;
        e_den = 1'b0; e_d = 8'd0; e_c = 2'b00; e_q = 10'h354;
        forever begin
            @(posedge clk_pix);
            cyc++;
            if (rst_pix) begin
                started = 1'b1; e_q = 10'h354; m_cnt = 0;
                e_den = 1'b0; e_c = 2'b00; e_d = 8'd0;
                s1_den = 1'b0; s1_c = 2'b00; s1_d = 8'd0;
            end else begin
                e_den = s1_den; e_d = s1_d; e_c = s1_c;
                e_q = model_sym(s1_den, s1_d, s1_c, m_cnt);
                s1_den = bus.den; s1_d = bus.d; s1_c = bus.c;
            end
            #1;
            if (started) begin
                d_cnt = $signed(dut.cnt_q);
                check("q_vs_model", int'(bus.q), int'(e_q));
                check("cnt_vs_model", d_cnt, m_cnt);
                check("cnt_bound", int'((d_cnt <= 16) && (d_cnt >= -16) && (d_cnt % 2 == 0)), 1);
                check("decode", int'(decode_sym(bus.q)),
                      int'(e_den ? {1'b0, e_d} : {1'b1, 6'd0, e_c}));
                if (lit_q.exists(cyc)) begin
                    check("lit_q_dut", int'(bus.q), int'(lit_q[cyc]));
                    check("lit_q_model", int'(e_q), int'(lit_q[cyc]));
                    check("lit_cnt_model", m_cnt, lit_cnt[cyc]);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic dn, input logic [7:0] dv, input logic [1:0] cv);
        @(negedge clk_pix);
        rst_pix = r; bus.den = dn; bus.d = dv; bus.c = cv;
    endtask

    task automatic drive_lit(input logic dn, input logic [7:0] dv, input logic [1:0] cv,
                             input logic [9:0] eq, input int ec);
        drive(1'b0, dn, dv, cv);
        lit_q[cyc + 2] = eq;
        lit_cnt[cyc + 2] = ec;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'($urandom), 8'($urandom), 2'($urandom));
            lit_q[cyc + 1] = 10'h354; lit_cnt[cyc + 1] = 0;
            lit_q[cyc + 2] = 10'h354; lit_cnt[cyc + 2] = 0;
        end
    endtask

    initial begin : stimulus
        rst_pix = 1'b1; bus.den = 1'($urandom); bus.d = 8'($urandom); bus.c = 2'($urandom);
        lit_q[1] = 10'h354; lit_cnt[1] = 0;
        do_reset(2);
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b0, 8'h5A, 2'b00, 10'h354, 0);
        drive_lit(1'b0, 8'h00, 2'b01, 10'h0AB, 0);
        drive_lit(1'b0, 8'hFF, 2'b10, 10'h154, 0);
        drive_lit(1'b0, 8'h00, 2'b11, 10'h2AB, 0);
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b1, 8'h00, 2'b11, 10'h100, -8);
        drive_lit(1'b1, 8'h00, 2'b11, 10'h3FF, 2);
        drive_lit(1'b1, 8'h00, 2'b11, 10'h100, -6);
        drive_lit(1'b1, 8'h00, 2'b11, 10'h3FF, 4);
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b1, 8'hFF, 2'b00, 10'h200, -8);
        drive_lit(1'b0, 8'h00, 2'b00, 10'h354, 0);
        drive_lit(1'b1, 8'h00, 2'b00, 10'h100, -8);
        drive_lit(1'b1, 8'h00, 2'b00, 10'h3FF, 2);
        drive_lit(1'b1, 8'h00, 2'b00, 10'h100, -6);
        drive(1'b0, 1'b1, 8'h00, 2'b00);
        do_reset(2);
        drive_lit(1'b1, 8'h00, 2'b00, 10'h100, -8);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(2);
            else drive(1'b0, ($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 2'b00);
        @(negedge clk_pix);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
